// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the lane-assembler state encoding.
package keccak_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;
  localparam int STATE_W   = LANE_W * NUM_LANES;

  // Rate in lanes (rate bits / LANE_W) for the standard SHA-3 family members.
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/keccak_lane_sipo.sv
// Serial-in/parallel-out lane assembler: packs lanes LSB-first into a state-sized block, closing on rate or in_last.
// out_valid one cycle after the closing lane; input stalls while the block is held, one bubble per block on handoff.
module keccak_lane_sipo #(
  parameter int LANE_W    = 64,
  parameter int NUM_LANES = 25,
  parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic [CNT_W-1:0]            rate_lanes,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W-1:0]           in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W*NUM_LANES-1:0] out_data,
  output logic [CNT_W-1:0]            out_lanes,
  output logic                        out_last
);
  import keccak_pkg::*;

  localparam logic [CNT_W-1:0] MAX_LANES = CNT_W'(NUM_LANES);

  sipo_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            rate_q, rate_d;
  logic [CNT_W-1:0]            lanes_q, lanes_d;
  logic                        last_q, last_d;
  logic [LANE_W*NUM_LANES-1:0] buf_q, buf_d;

  logic [CNT_W-1:0] rate_in_sane;
  logic [CNT_W-1:0] rate_eff;
  logic [CNT_W-1:0] idx_inc;

  // Out-of-range rates fall back to a full-state block.
  assign rate_in_sane = ((rate_lanes == '0) || (rate_lanes > MAX_LANES)) ? MAX_LANES : rate_lanes;
  // Lane 0 compares against the live rate since it is latched in that same cycle.
  assign rate_eff     = (idx_q == '0) ? rate_in_sane : rate_q;
  assign idx_inc      = idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rate_d  = rate_q;
    lanes_d = lanes_q;
    last_d  = last_q;
    buf_d   = buf_q;
    if (clear) begin
      state_d = ST_FILL;
      idx_d   = '0;
      lanes_d = '0;
      last_d  = 1'b0;
      buf_d   = '0;
    end else if (state_q == ST_FILL) begin
      if (in_valid) begin
        buf_d[int'(idx_q)*LANE_W +: LANE_W] = in_data;
        idx_d = idx_inc;
        if (idx_q == '0) begin
          rate_d = rate_in_sane;
        end
        if ((idx_inc == rate_eff) || in_last) begin
          state_d = ST_HOLD;
          lanes_d = idx_inc;
          last_d  = in_last;
        end
      end
    end else if (out_ready) begin
      state_d = ST_FILL;
      idx_d   = '0;
      lanes_d = '0;
      last_d  = 1'b0;
      buf_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      rate_q  <= MAX_LANES;
      lanes_q <= '0;
      last_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rate_q  <= rate_d;
      lanes_q <= lanes_d;
      last_q  <= last_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = buf_q;
  assign out_lanes = lanes_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_keccak_lane_sipo.sv
// Directed bench for keccak_lane_sipo: rate close, backpressure, early last, rate latch, clear, async reset.
module tb_keccak_lane_sipo;

  localparam int LW = 64;
  localparam int NL = 25;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic [CW-1:0]   rate_lanes = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [LW-1:0]   in_data = '0;
  logic            in_last = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LW*NL-1:0] out_data;
  logic [CW-1:0]   out_lanes;
  logic            out_last;

  int checks = 0;
  int failures = 0;
  logic [LW*NL-1:0] exp_dat;

  keccak_lane_sipo #(.LANE_W(LW), .NUM_LANES(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .rate_lanes(rate_lanes),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lanes(out_lanes), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (out_data !== '0 || out_lanes !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs lanes=%0d last=%b data_nonzero=%b required 0/0/0", out_lanes, out_last, |out_data);
    end
  endtask

  task automatic test_rate17();
    rate_lanes = 5'd17;
    exp_dat = '0;
    for (int k = 0; k < 16; k++) begin
      send(LW'(k + 1), 1'b0);
      exp_dat[k*LW +: LW] = LW'(k + 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL r17_early out_valid=%b required 0 after 16 lanes", out_valid);
    end
    send(64'h11, 1'b0);
    exp_dat[16*LW +: LW] = 64'h11;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL r17_valid out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    checks++;
    if (out_lanes !== 5'd17 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL r17_meta lanes=%0d last=%b required 17/0", out_lanes, out_last);
    end
    checks++;
    if (out_data !== exp_dat) begin
      failures++;
      $display("FAIL r17_data got %h required %h", out_data[17*LW-1:0], exp_dat[17*LW-1:0]);
    end
    handoff();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL r17_handoff in_ready=%b out_valid=%b data_nonzero=%b required 1/0/0", in_ready, out_valid, |out_data);
    end
  endtask

  task automatic test_backpressure();
    rate_lanes = 5'd25;
    exp_dat = '0;
    for (int k = 0; k < 25; k++) begin
      send(64'hA0 + LW'(k), 1'b0);
      exp_dat[k*LW +: LW] = 64'hA0 + LW'(k);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = 64'hDEAD;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_dat || out_lanes !== 5'd25) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d in_ready=%b out_valid=%b lanes=%0d data_ok=%b required 0/1/25/1",
                 c, in_ready, out_valid, out_lanes, out_data === exp_dat);
      end
      step();
    end
    in_valid = 1'b0;
    handoff();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_early_last();
    rate_lanes = 5'd9;
    exp_dat = '0;
    for (int k = 0; k < 4; k++) begin
      send(64'hC1 + LW'(k), k == 3);
      exp_dat[k*LW +: LW] = 64'hC1 + LW'(k);
    end
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd4 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL last4_meta valid=%b lanes=%0d last=%b required 1/4/1", out_valid, out_lanes, out_last);
    end
    checks++;
    if (out_data !== exp_dat) begin
      failures++;
      $display("FAIL last4_data got %h required %h", out_data[5*LW-1:0], exp_dat[5*LW-1:0]);
    end
    handoff();
    rate_lanes = 5'd17;
    send(64'hD1, 1'b1);
    exp_dat = '0;
    exp_dat[LW-1:0] = 64'hD1;
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd1 || out_last !== 1'b1 || out_data !== exp_dat) begin
      failures++;
      $display("FAIL last_lane0 valid=%b lanes=%0d last=%b data_ok=%b required 1/1/1/1",
               out_valid, out_lanes, out_last, out_data === exp_dat);
    end
    handoff();
  endtask

  task automatic test_rate_latch();
    rate_lanes = 5'd17;
    for (int k = 0; k < 3; k++) send(64'h100 + LW'(k), 1'b0);
    rate_lanes = 5'd9;
    for (int k = 3; k < 16; k++) send(64'h100 + LW'(k), 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latch_nochange out_valid=%b required 0 after 16 lanes", out_valid);
    end
    send(64'h110, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd17) begin
      failures++;
      $display("FAIL latch_close17 valid=%b lanes=%0d required 1/17", out_valid, out_lanes);
    end
    handoff();
    for (int k = 0; k < 8; k++) send(64'h200 + LW'(k), 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL latch_r9_early out_valid=%b required 0 after 8 lanes", out_valid);
    end
    send(64'h208, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd9 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL latch_r9_last valid=%b lanes=%0d last=%b required 1/9/1", out_valid, out_lanes, out_last);
    end
    handoff();
  endtask

  task automatic test_clear();
    rate_lanes = 5'd17;
    for (int k = 0; k < 5; k++) send(64'hE0 + LW'(k), 1'b0);
    clear = 1'b1;
    send(64'hEE, 1'b0);
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL clear_fill valid=%b in_ready=%b data_nonzero=%b required 0/1/0", out_valid, in_ready, |out_data);
    end
    exp_dat = '0;
    for (int k = 0; k < 17; k++) begin
      send(64'hF0 + LW'(k), 1'b0);
      exp_dat[k*LW +: LW] = 64'hF0 + LW'(k);
    end
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd17 || out_data !== exp_dat) begin
      failures++;
      $display("FAIL clear_newblock valid=%b lanes=%0d data_ok=%b required 1/17/1", out_valid, out_lanes, out_data === exp_dat);
    end
    clear = 1'b1;
    out_ready = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_lanes !== '0) begin
      failures++;
      $display("FAIL clear_hold valid=%b in_ready=%b lanes=%0d data_nonzero=%b required 0/1/0/0",
               out_valid, in_ready, out_lanes, |out_data);
    end
  endtask

  task automatic test_async_reset();
    rate_lanes = 5'd9;
    for (int k = 0; k < 9; k++) send(64'h300 + LW'(k), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      failures++;
      $display("FAIL arst_immediate valid=%b data_nonzero=%b required 0/0", out_valid, |out_data);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_lanes !== '0) begin
      failures++;
      $display("FAIL arst_release in_ready=%b lanes=%0d required 1/0", in_ready, out_lanes);
    end
    rate_lanes = 5'd0;
    exp_dat = '0;
    for (int k = 0; k < 24; k++) begin
      send(64'h400 + LW'(k), 1'b0);
      exp_dat[k*LW +: LW] = 64'h400 + LW'(k);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rate0_early out_valid=%b required 0 after 24 lanes", out_valid);
    end
    send(64'h418, 1'b0);
    exp_dat[24*LW +: LW] = 64'h418;
    checks++;
    if (out_valid !== 1'b1 || out_lanes !== 5'd25 || out_data !== exp_dat) begin
      failures++;
      $display("FAIL rate0_full valid=%b lanes=%0d data_ok=%b required 1/25/1", out_valid, out_lanes, out_data === exp_dat);
    end
    handoff();
  endtask

  initial begin
    test_reset();
    test_rate17();
    test_backpressure();
    test_early_last();
    test_rate_latch();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
